sqrt_responder: RTL and testbench

Memory-mapped integer square-root engine: the responding end of the Start/Ack program-launch protocol used by the program-3 test benches. A host loads a 16-bit operand into data memory bytes 16 (high) and 17 (low), pulses Start, then waits for Ack. The block reads the operand, computes an 8-bit square root with a bit-serial restoring algorithm, writes the result to byte 18 and raises Ack. It is a drop-in replacement for the CPU under the existing program-3 bench: the same port names, the same memory instance path and the same addresses.

---
 rtl/sqrt_pkg.sv | 22 ++
 rtl/data_mem.sv | 34 +++
 rtl/sqrt_responder.sv | 140 ++++++++++++++
 tb/tb_sqrt_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the memory-mapped square-root responder.
package sqrt_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      RD_HI,
      RD_LO,
      CALC,
      WR,
      DONE
   } state_t;

   localparam int DEF_ADDR_HI  = 16;
   localparam int DEF_ADDR_LO  = 17;
   localparam int DEF_ADDR_RES = 18;

   localparam int OP_W   = 16;
   localparam int ROOT_W = 8;
   localparam int REM_W  = 11;

endpackage

// File: rtl/data_mem.sv
// Byte-wide data memory: combinational read through a two-way address mux
// (operand high/low byte), synchronous write to the fixed result address.
// Contents are not reset; the host loads them by back door.
module data_mem #(
   parameter int AW       = 8,
   parameter int ADDR_HI  = 16,
   parameter int ADDR_LO  = 17,
   parameter int ADDR_RES = 18
) (
   input  logic       clk,
   input  logic       rd_lo_sel,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data
);

   logic [7:0]    Core [0:(2**AW)-1];
   logic [AW-1:0] rd_addr;

   // Read address selects the operand byte requested by the FSM.
   always_comb begin
      rd_addr = rd_lo_sel ? AW'(ADDR_LO) : AW'(ADDR_HI);
   end

   assign rd_data = Core[rd_addr];

   // Only the result byte is ever written.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         Core[AW'(ADDR_RES)] <= wr_data;
      end
   end

endmodule

// File: rtl/sqrt_responder.sv
// Start/Ack integer square-root engine. Reads a 16-bit operand from data
// memory, computes the 8-bit root with a restoring bit-serial algorithm and
// writes it back. Optional macro SQRT_ROUND_EN rounds the written result to
// nearest (saturating at 8'hFF) instead of truncating.
//
// state | meaning
// IDLE  | waiting for Start
// ARMED | Start seen high, waiting for its fall
// RD_HI | latch operand high byte
// RD_LO | latch operand low byte, clear root/rem, i = 7
// CALC  | one root bit per cycle, i = 7 down to 0
// WR    | write result byte
// DONE  | Ack high until the next Start
module sqrt_responder
   import sqrt_pkg::*;
#(
   parameter int ADDR_HI  = DEF_ADDR_HI,
   parameter int ADDR_LO  = DEF_ADDR_LO,
   parameter int ADDR_RES = DEF_ADDR_RES,
   parameter int AW       = 8
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Start,
   output logic Ack
);

   state_t              state_q, state_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [ROOT_W-1:0]   root_q, root_d;
   logic [REM_W-1:0]    rem_q, rem_d;
   logic [2:0]          i_q, i_d;

   logic [7:0]          rd_data;
   logic                rd_lo_sel;
   logic                wr_en;
   logic [7:0]          wr_data;
   logic [REM_W-1:0]    rem_shift;
   logic [REM_W-1:0]    trial;

   data_mem #(
      .AW       (AW),
      .ADDR_HI  (ADDR_HI),
      .ADDR_LO  (ADDR_LO),
      .ADDR_RES (ADDR_RES)
   ) DM1 (
      .clk       (Clk),
      .rd_lo_sel (rd_lo_sel),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .rd_data   (rd_data)
   );

   // One restoring step: bring down the next operand bit pair, form trial.
   always_comb begin
      rem_shift = {rem_q[REM_W-3:0], op_q[{i_q, 1'b0} +: 2]};
      trial     = {1'b0, root_q, 2'b01};
   end

   // Result byte; rounding adds one when the leftover exceeds the root.
   always_comb begin
      wr_data = root_q;
`ifdef SQRT_ROUND_EN
      if (rem_q > {3'b000, root_q}) begin
         wr_data = (root_q == 8'hFF) ? 8'hFF : root_q + 8'd1;
      end
`endif
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      root_d    = root_q;
      rem_d     = rem_q;
      i_d       = i_q;
      rd_lo_sel = 1'b0;
      wr_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Start) state_d = ARMED;
         end
         ARMED: begin
            if (!Start) state_d = RD_HI;
         end
         RD_HI: begin
            op_d[15:8] = rd_data;
            state_d    = RD_LO;
         end
         RD_LO: begin
            rd_lo_sel = 1'b1;
            op_d[7:0] = rd_data;
            root_d    = '0;
            rem_d     = '0;
            i_d       = 3'd7;
            state_d   = CALC;
         end
         CALC: begin
            if (rem_shift >= trial) begin
               rem_d  = rem_shift - trial;
               root_d = {root_q[ROOT_W-2:0], 1'b1};
            end else begin
               rem_d  = rem_shift;
               root_d = {root_q[ROOT_W-2:0], 1'b0};
            end
            i_d = i_q - 3'd1;
            if (i_q == 3'd0) state_d = WR;
         end
         WR: begin
            // A reset landing on this edge must not commit the result.
            wr_en   = Reset;
            state_d = DONE;
         end
         DONE: begin
            if (Start) state_d = ARMED;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         root_q  <= '0;
         rem_q   <= '0;
         i_q     <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         root_q  <= root_d;
         rem_q   <= rem_d;
         i_q     <= i_d;
      end
   end

   assign Ack = (state_q == DONE);

endmodule

// File: tb/tb_sqrt_responder.sv
// Bench for sqrt_responder: fixed vectors, corner sequences, random operands
// against an arithmetic square-root model. Honours SQRT_ROUND_EN.
module tb_sqrt_responder;
   import sqrt_pkg::*;

   logic Clk;
   logic Reset;
   logic Start;
   logic Ack;

   int total;
   int bad;

`ifdef SQRT_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   sqrt_responder dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Start (Start),
      .Ack   (Ack)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [15:0] op;
      logic [7:0]  exp_floor;
      logic [7:0]  exp_round;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic int ref_sqrt(input int op, input bit rnd);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) <= op) r++;
      if (rnd && (op >= r * r + r + 1) && (r < 255)) r++;
      return r;
   endfunction

   task automatic load_op(input logic [15:0] op);
      dut.DM1.Core[16] = op[15:8];
      dut.DM1.Core[17] = op[7:0];
   endtask

   // Count edges after Start has been driven low until Ack rises (bounded).
   task automatic wait_ack(output int lat);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         tick();
         lat++;
         if (Ack) seen = 1'b1;
      end
      if (!seen) lat = -1;
   endtask

   // Full run: Start high two cycles, fall, wait, check latency/result/neighbours.
   task automatic run_check(input string nm, input logic [15:0] op, input int exp_res);
      int lat;
      load_op(op);
      dut.DM1.Core[15] = 8'h3C;
      dut.DM1.Core[19] = 8'hC3;
      Start = 1'b1;
      tick();
      tick();
      Start = 1'b0;
      wait_ack(lat);
      chk({nm, " latency"}, lat, 12);
      chk({nm, " result"}, int'(dut.DM1.Core[18]), exp_res);
      chk({nm, " ack"}, int'(Ack), 1);
      chk({nm, " hi untouched"}, int'(dut.DM1.Core[16]), int'(op[15:8]));
      chk({nm, " lo untouched"}, int'(dut.DM1.Core[17]), int'(op[7:0]));
      chk({nm, " neighbours"}, int'({dut.DM1.Core[15], dut.DM1.Core[19]}), 16'h3CC3);
   endtask

   initial begin
      int lat;
      int errs;
      logic [15:0] rop;

      total = 0;
      bad   = 0;

      vecs[0] = '{16'd190,   8'h0D, 8'h0E};
      vecs[1] = '{16'd0,     8'h00, 8'h00};
      vecs[2] = '{16'd144,   8'h0C, 8'h0C};
      vecs[3] = '{16'd65535, 8'hFF, 8'hFF};
      vecs[4] = '{16'd1000,  8'h1F, 8'h20};
      vecs[5] = '{16'd1,     8'h01, 8'h01};
      vecs[6] = '{16'd2,     8'h01, 8'h01};
      vecs[7] = '{16'd3,     8'h01, 8'h02};
      vecs[8] = '{16'd65025, 8'hFF, 8'hFF};
      vecs[9] = '{16'd65024, 8'hFE, 8'hFF};

      Reset = 1'b0;
      Start = 1'b0;
      for (int a = 0; a < 256; a++) dut.DM1.Core[a] = 8'h00;
      tick();
      tick();
      chk("reset ack", int'(Ack), 0);
      chk("reset state", int'(dut.state_q), int'(IDLE));
      Reset = 1'b1;
      tick();
      chk("idle ack", int'(Ack), 0);

      // Table vectors
      for (int v = 0; v < 10; v++) begin
         dut.DM1.Core[18] = 8'h5A;
         run_check($sformatf("vec%0d", v), vecs[v].op,
                   RND ? int'(vecs[v].exp_round) : int'(vecs[v].exp_floor));
      end

      // Back-to-back: Ack falls on the Start edge, then the next run completes
      load_op(16'd1000);
      Start = 1'b1;
      tick();
      chk("b2b ack falls", int'(Ack), 0);
      Start = 1'b0;
      wait_ack(lat);
      chk("b2b latency", lat, 12);
      chk("b2b result", int'(dut.DM1.Core[18]), RND ? 8'h20 : 8'h1F);

      // Reset for one cycle during CALC aborts without writing
      dut.DM1.Core[18] = 8'hA5;
      load_op(16'd190);
      Start = 1'b1;
      tick();
      tick();
      Start = 1'b0;
      repeat (4) tick();
      chk("abort in calc", int'(dut.state_q), int'(CALC));
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      chk("abort ack", int'(Ack), 0);
      chk("abort state", int'(dut.state_q), int'(IDLE));
      chk("abort mem", int'(dut.DM1.Core[18]), 8'hA5);
      errs = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (Ack || dut.DM1.Core[18] != 8'hA5) errs++;
      end
      chk("abort quiet", errs, 0);
      run_check("after abort", 16'd190, RND ? 8'h0E : 8'h0D);

      // Start held high 50 cycles: no write, Ack low
      dut.DM1.Core[18] = 8'h77;
      load_op(16'd144);
      Start = 1'b1;
      errs = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (Ack || dut.DM1.Core[18] != 8'h77) errs++;
      end
      chk("long start quiet", errs, 0);
      Start = 1'b0;
      wait_ack(lat);
      chk("long start latency", lat, 12);
      chk("long start result", int'(dut.DM1.Core[18]), 8'h0C);

      // Random operands against the arithmetic model
      for (int n = 0; n < 30; n++) begin
         rop = 16'($urandom_range(0, 65535));
         run_check($sformatf("rand%0d op=%0d", n, rop), rop, ref_sqrt(int'(rop), RND));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
